// File: rtl/regfile_scan_ctrl_pkg.sv
// Shared types and derivations for the bit-serial register file scan controller.
package regfile_scan_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic REQ_EXEC = 1'b0;
    localparam logic REQ_LDST = 1'b1;

    function automatic int unsigned num_phases(input int unsigned reg_bits,
                                               input int unsigned nshift);
        return reg_bits / nshift;
    endfunction

    function automatic int unsigned phase_bits(input int unsigned reg_bits,
                                               input int unsigned nshift);
        return $clog2(reg_bits / nshift);
    endfunction

endpackage

// File: rtl/regfile_scan_ctrl_if.sv
// Request bus of the two scan requesters (slice k of each vector belongs to requester k).
interface regfile_scan_ctrl_if #(
    parameter int LOG2_NR = 3
);
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [2*LOG2_NR-1:0] req_index;
    logic [2*LOG2_NR-1:0] req_index2;
    logic [1:0]           req_dual;

    modport master (output req_valid, req_index, req_index2, req_dual, input req_ready);
    modport slave  (input req_valid, req_index, req_index2, req_dual, output req_ready);
endinterface

// File: rtl/regfile_scan_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; a tie goes to the requester not granted most recently.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       update,
    output logic       winner
);
    logic rr_last;

    always_comb begin
        winner = ~rr_last;
        case (valid)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            default: winner = ~rr_last;
        endcase
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_last <= 1'b1;
        else if (update)
            rr_last <= winner;
    end
endmodule

// File: rtl/regfile_scan_ctrl.sv
// Scan sequencer/arbiter for the bit-serial register file.
// Optional stall support: define REGFILE_SCAN_CTRL_STALL_EN.
module regfile_scan_ctrl
    import regfile_scan_ctrl_pkg::*;
#(
    parameter  int          LOG2_NR    = 3,
    parameter  int          REG_BITS   = 8,
    parameter  int          NSHIFT     = 2,
    localparam int unsigned NUM_PHASES = num_phases(REG_BITS, NSHIFT),
    localparam int unsigned PHASE_BITS = phase_bits(REG_BITS, NSHIFT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_scan_ctrl_if.slave    req,
    input  logic                  stall,
    output logic [LOG2_NR-1:0]    reg_index,
    output logic [LOG2_NR-1:0]    reg_index2,
    output logic                  do_scan,
    output logic                  do_scan2,
    output logic                  busy,
    output logic                  owner,
    output logic [PHASE_BITS-1:0] phase,
    output logic                  first,
    output logic                  last,
    output logic                  done
);
    state_t                state_q, state_next;
    logic [PHASE_BITS-1:0] phase_q, phase_next;
    logic                  owner_q, owner_next;
    logic                  dual_q, dual_next;
    logic [LOG2_NR-1:0]    idx_q, idx_next, idx2_q, idx2_next;
    logic                  stall_eff, winner, open, accept, scan_go, at_last;
    logic [1:0]            ready;

`ifdef REGFILE_SCAN_CTRL_STALL_EN
    assign stall_eff = stall;
`else
    // Port kept for pin compatibility; masked so it never affects the scan.
    assign stall_eff = stall & 1'b0;
`endif

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (req.req_valid),
        .update (accept),
        .winner (winner)
    );

    assign at_last = (phase_q == PHASE_BITS'(NUM_PHASES - 1));
    assign scan_go = (state_q == ST_SCAN) & ~stall_eff;
    assign do_scan  = scan_go;
    assign do_scan2 = scan_go & dual_q;
    assign first    = scan_go & (phase_q == '0);
    assign last     = scan_go & at_last;
    assign done     = last & ~stall_eff;

    // Accepting in the final slice lets the next scan start without a bubble.
    assign open     = (state_q == ST_IDLE) | done;
    assign ready[0] = open & req.req_valid[0] & (winner == REQ_EXEC);
    assign ready[1] = open & req.req_valid[1] & (winner == REQ_LDST);
    assign accept   = |ready;
    assign req.req_ready = ready;

    assign busy       = (state_q == ST_SCAN);
    assign owner      = owner_q;
    assign phase      = phase_q;
    assign reg_index  = idx_q;
    assign reg_index2 = idx2_q;

    always_comb begin
        state_next = state_q;
        phase_next = phase_q;
        owner_next = owner_q;
        dual_next  = dual_q;
        idx_next   = idx_q;
        idx2_next  = idx2_q;
        if (accept) begin
            state_next = ST_SCAN;
            phase_next = '0;
            owner_next = winner;
            dual_next  = req.req_dual[winner];
            idx_next   = winner ? req.req_index[2*LOG2_NR-1:LOG2_NR]  : req.req_index[LOG2_NR-1:0];
            idx2_next  = winner ? req.req_index2[2*LOG2_NR-1:LOG2_NR] : req.req_index2[LOG2_NR-1:0];
        end else if (scan_go) begin
            if (at_last) begin
                state_next = ST_IDLE;
                phase_next = '0;
            end else begin
                phase_next = phase_q + PHASE_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            owner_q <= 1'b0;
            dual_q  <= 1'b0;
            idx_q   <= '0;
            idx2_q  <= '0;
        end else begin
            state_q <= state_next;
            phase_q <= phase_next;
            owner_q <= owner_next;
            dual_q  <= dual_next;
            idx_q   <= idx_next;
            idx2_q  <= idx2_next;
        end
    end
endmodule

// File: doc/regfile_scan_ctrl.md
# regfile_scan_ctrl

Sequencer and arbiter for the bit-serial register file. It accepts whole-register scan requests from two requesters (port 0: ALU/execute, port 1: load/store), grants them round-robin, and drives the register file's index and scan-enable inputs for exactly REG_BITS/NSHIFT consecutive cycles per request. It also exports phase, first, last and done markers so the datapath can align its serial operands with the scan.

## Interface
Parameters:
- LOG2_NR, 3: log2 of the register count; sets the index width.
- REG_BITS, 8: register width; must be a multiple of NSHIFT.
- NSHIFT, 2: bits shifted per cycle. NUM_PHASES = REG_BITS/NSHIFT, and must be ≥ 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  request valid, one bit per requester.
- req_ready  out  2  accept strobe; a transfer occurs when req_valid[k] & req_ready[k].
- req_index  in  2*LOG2_NR  primary register index per requester; requester k uses slice k.
- req_index2  in  2*LOG2_NR  secondary register index per requester.
- req_dual  in  2  per requester: also scan the secondary port.
- stall  in  1  freezes the active scan for this cycle.
- reg_index  out  LOG2_NR  drives the regfile's reg_index.
- reg_index2  out  LOG2_NR  drives the regfile's reg_index2.
- do_scan  out  1  drives the regfile's do_scan.
- do_scan2  out  1  drives the regfile's do_scan2.
- busy  out  1  a scan is in progress.
- owner  out  1  requester that owns the current scan.
- phase  out  clog2(NUM_PHASES)  index of the NSHIFT-bit slice being scanned (0 = LSBs).
- first  out  1  do_scan & (phase == 0).
- last  out  1  do_scan & (phase == NUM_PHASES-1).
- done  out  1  last & ~stall; the final slice completes this cycle.

## Operation
- Two states:
  - IDLE: busy = 0.
  - SCAN: busy = 1.
- Registers:
  - state, phase, owner, rr_last (the requester granted most recently).
  - Latched copies of reg_index, reg_index2 and dual.
- Accept window: open = (state == IDLE) | done.
- Arbitration:
  - If only one req_valid bit is set, that requester wins.
  - If both are set, the winner is ~rr_last.
  - req_ready[k] = open & winner == k & req_valid[k]. req_ready is combinational and never depends on its own output.
- On accept:
  - Latch the winner's indices and dual flag.
  - Set owner = winner and rr_last = winner.
  - Set phase = 0 and state = SCAN.
- In SCAN:
  - do_scan = ~stall.
  - do_scan2 = ~stall & dual_latched.
  - phase increments when ~stall.
  - After the increment from NUM_PHASES-1:
    - If a new request was accepted, restart at phase 0 (back-to-back, no bubble).
    - Otherwise go to IDLE.
- When reg_index2 equals reg_index with dual set, the regfile's own port-1 priority applies; this block does not check for it.
- In IDLE, do_scan, do_scan2, first, last and done are 0. reg_index and reg_index2 hold their last values.

## Timing
- Reset values (asynchronous, while rst_n = 0):
  - state = IDLE, phase = 0, owner = 0, rr_last = 1 (so port 0 wins the first tie).
  - Latched indices = 0, dual = 0.
  - Therefore every output is 0.
- Latency: a request accepted in cycle t gives do_scan = 1 in cycles t+1 … t+NUM_PHASES, assuming no stall.
- Each stall cycle adds exactly one cycle and does not advance phase.
- Back-to-back: throughput is one request per NUM_PHASES cycles with zero idle cycles between scans.
- Reset asserted mid-scan aborts immediately. The register being scanned is left partially rotated, and recovering it is the issuer's responsibility.
- A requester may drop req_valid before it is accepted. Its indices only need to be stable in the accept cycle.

## Configuration
- Macro: REGFILE_SCAN_CTRL_STALL_EN.
- Defined: stall behaves as described above.
- Undefined:
  - The stall port remains but is ignored and treated as 0.
  - done = last.
  - Every scan takes exactly NUM_PHASES cycles.

## Structure
- Shared package:
  - State encoding (ST_IDLE, ST_SCAN).
  - NUM_PHASES and PHASE_BITS derivation.
  - Requester ID constants (REQ_EXEC = 0, REQ_LDST = 1).
- Sub-module rr_arb2: a two-input round-robin arbiter holding rr_last, with inputs valid[1:0] and update and output winner.

## Test plan
- Single request on port 0 (index 3, no dual) at cycle 0 → do_scan with reg_index = 3 for cycles 1–4; first at 1; last and done at 4; busy falls after cycle 4; do_scan2 stays 0.
- Both ports valid continuously, port 0 index 1 and port 1 index 5 with dual, index2 = 2 → grants alternate 0,1,0,1 with no bubbles; do_scan2 = 1 only during port-1 scans, with reg_index2 = 2.
- Stall for 2 cycles at phase 2 (macro defined) → scan lasts 6 cycles, phase holds at 2, do_scan = 0 during the stalls, done asserts once.
- Same stall stimulus with the macro undefined → 4-cycle scan, stall ignored.
- rst_n asserted at phase 1 → all outputs 0 immediately; after release, port 0 wins the first tie.
- req_valid on port 1 pulsed for one cycle during a port-0 scan, outside the last phase → req_ready stays 0 and no grant is recorded.
